// File: rtl/nios2os_pio_gen.sv
// Avalon-MM parallel I/O port: per-bit direction, atomic set/clear of outputs,
// synchronised inputs, edge capture and a maskable level interrupt.
module nios2os_pio_gen #(
    parameter int unsigned      WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int unsigned      EDGE_TYPE   = 0,
    parameter int unsigned      SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] oe,
    output logic             irq
);

    localparam int unsigned ARM_W   = 3;
    localparam int unsigned ARM_CNT = SYNC_STAGES + 1;

    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_DIR     = 3'd1;
    localparam logic [2:0] ADDR_IRQMASK = 3'd2;
    localparam logic [2:0] ADDR_EDGECAP = 3'd3;
    localparam logic [2:0] ADDR_OUTSET  = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

    logic [WIDTH-1:0]                  r_data_out;
    logic [WIDTH-1:0]                  r_dir;
    logic [WIDTH-1:0]                  r_irqmask;
    logic [WIDTH-1:0]                  r_edgecap;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
    logic [WIDTH-1:0]                  r_in_prev;
    logic [ARM_W-1:0]                  r_arm_cnt;

    logic             w_wr;
    logic [WIDTH-1:0] w_wdata;
    logic [WIDTH-1:0] w_in_sync;
    logic [WIDTH-1:0] w_edge;
    logic             w_armed;
    logic [WIDTH-1:0] w_cap_set;
    logic [WIDTH-1:0] w_cap_clr;
    logic [WIDTH-1:0] w_rdata;
    logic             w_unused_wd;

    assign w_wr        = chipselect & ~write_n;
    assign w_wdata     = writedata[WIDTH-1:0];
    assign w_unused_wd = ^writedata;
    assign w_in_sync   = r_sync[SYNC_STAGES-1];
    assign w_armed     = (r_arm_cnt == ARM_W'(ARM_CNT));

    // Edge detector on the synchronised input
    always_comb begin
        w_edge = '0;
        if (EDGE_TYPE == 0) begin
            w_edge = w_in_sync & ~r_in_prev;
        end else if (EDGE_TYPE == 1) begin
            w_edge = ~w_in_sync & r_in_prev;
        end else begin
            w_edge = w_in_sync ^ r_in_prev;
        end
    end

    // Only input bits capture; a coincident edge overrides the W1C clear
    assign w_cap_set = (w_armed) ? (w_edge & ~r_dir) : '0;
    assign w_cap_clr = (w_wr && address == ADDR_EDGECAP) ? w_wdata : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data_out <= RESET_VALUE;
            r_dir      <= '0;
            r_irqmask  <= '0;
            r_edgecap  <= '0;
            r_sync     <= '0;
            r_in_prev  <= '0;
            r_arm_cnt  <= '0;
        end else begin
            r_sync    <= {r_sync[SYNC_STAGES-2:0], in_port};
            r_in_prev <= w_in_sync;
            r_edgecap <= (r_edgecap & ~w_cap_clr) | w_cap_set;
            if (!w_armed) begin
                r_arm_cnt <= r_arm_cnt + ARM_W'(1);
            end
            if (w_wr) begin
                case (address)
                    ADDR_DATA:    r_data_out <= w_wdata;
                    ADDR_DIR:     r_dir      <= w_wdata;
                    ADDR_IRQMASK: r_irqmask  <= w_wdata;
                    ADDR_OUTSET:  r_data_out <= r_data_out | w_wdata;
                    ADDR_OUTCLR:  r_data_out <= r_data_out & ~w_wdata;
                    default:      ;
                endcase
            end
        end
    end

    // Zero-wait-state read mux
    always_comb begin
        w_rdata = '0;
        case (address)
            ADDR_DATA:    w_rdata = (r_data_out & r_dir) | (w_in_sync & ~r_dir);
            ADDR_DIR:     w_rdata = r_dir;
            ADDR_IRQMASK: w_rdata = r_irqmask;
            ADDR_EDGECAP: w_rdata = r_edgecap;
            default:      w_rdata = '0;
        endcase
    end

    assign readdata = 32'(w_rdata);
    assign out_port = r_data_out;
    assign oe       = r_dir;
    assign irq      = |(r_edgecap & r_irqmask);

endmodule

// File: tb/tb_nios2os_pio_gen.sv
// Scoreboard bench for nios2os_pio_gen: stimulus queues expected values,
// a negedge monitor pops and compares them against the live DUT outputs.
module tb_nios2os_pio_gen;

    localparam int unsigned WIDTH = 8;

    localparam int unsigned SIG_RD  = 0;
    localparam int unsigned SIG_OUT = 1;
    localparam int unsigned SIG_OE  = 2;
    localparam int unsigned SIG_IRQ = 3;

    logic             clk        = 1'b0;
    logic             reset_n    = 1'b0;
    logic [2:0]       address    = 3'd0;
    logic             chipselect = 1'b0;
    logic             write_n    = 1'b1;
    logic [31:0]      writedata  = 32'd0;
    logic [31:0]      readdata;
    logic [WIDTH-1:0] in_port    = 8'h3C;
    logic [WIDTH-1:0] out_port;
    logic [WIDTH-1:0] oe;
    logic             irq;

    nios2os_pio_gen #(
        .WIDTH      (WIDTH),
        .RESET_VALUE(8'hA5),
        .EDGE_TYPE  (0),
        .SYNC_STAGES(2)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .in_port   (in_port),
        .out_port  (out_port),
        .oe        (oe),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int unsigned sig;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    function automatic logic [31:0] observe(input int unsigned sig);
        case (sig)
            SIG_RD:  return readdata;
            SIG_OUT: return 32'(out_port);
            SIG_OE:  return 32'(oe);
            default: return 32'(irq);
        endcase
    endfunction

    // Monitor: compare every queued expectation against the settled outputs
    always @(negedge clk) begin
        while (sb_q.size() != 0) begin
            exp_t        e;
            logic [31:0] act;
            e   = sb_q.pop_front();
            act = observe(e.sig);
            n_vec++;
            if (act !== e.exp) begin
                n_miss++;
                $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", e.name, act, e.exp, $time);
            end
        end
    end

    task automatic push(input string name, input int unsigned sig, input logic [31:0] exp);
        exp_t e;
        e.name = name;
        e.sig  = sig;
        e.exp  = exp;
        sb_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d, input logic cs);
        chipselect = cs;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        tick(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic read_exp(input logic [2:0] a, input string name, input logic [31:0] exp);
        address = a;
        push(name, SIG_RD, exp);
        tick(1);
    endtask

    initial begin
        // Reset state (held in reset, before any clock edge)
        #1;
        push("rst_out_port", SIG_OUT, 32'h0000_00A5);
        push("rst_oe", SIG_OE, 32'h0);
        push("rst_irq", SIG_IRQ, 32'h0);
        push("rst_rd_data", SIG_RD, 32'h0);
        tick(2);
        reset_n = 1'b1;
        tick(2);
        read_exp(3'd0, "sync_in_read", 32'h0000_003C);
        tick(2);
        read_exp(3'd3, "no_capture_after_release", 32'h0);

        // Direction mix on DATA read
        bus_write(3'd1, 32'h0000_000F, 1'b1);
        push("oe_after_dir", SIG_OE, 32'h0000_000F);
        bus_write(3'd0, 32'hFFFF_FFFF, 1'b1);
        push("out_after_data", SIG_OUT, 32'h0000_00FF);
        in_port = 8'h50;
        tick(2);
        read_exp(3'd0, "data_mixed_read", 32'h0000_005F);

        // Atomic set / clear
        bus_write(3'd0, 32'h0000_000F, 1'b1);
        bus_write(3'd5, 32'h0000_0003, 1'b1);
        push("outclr", SIG_OUT, 32'h0000_000C);
        bus_write(3'd4, 32'h0000_0080, 1'b1);
        push("outset", SIG_OUT, 32'h0000_008C);
        read_exp(3'd4, "outset_reads_0", 32'h0);
        read_exp(3'd5, "outclr_reads_0", 32'h0);
        read_exp(3'd1, "dir_readback", 32'h0000_000F);

        // Ignored writes: chipselect low, unused address
        bus_write(3'd0, 32'h0000_0000, 1'b0);
        push("cs0_write_ignored", SIG_OUT, 32'h0000_008C);
        bus_write(3'd6, 32'h0000_00FF, 1'b1);
        read_exp(3'd6, "addr6_reads_0", 32'h0);
        push("addr6_no_alias", SIG_OUT, 32'h0000_008C);

        // Rising edge on bit 4 -> capture + irq after 3 edges
        bus_write(3'd1, 32'h0, 1'b1);
        in_port = 8'h40;
        tick(4);
        bus_write(3'd3, 32'h0000_00FF, 1'b1);
        read_exp(3'd3, "edgecap_cleared", 32'h0);
        bus_write(3'd2, 32'h0000_0010, 1'b1);
        read_exp(3'd2, "irqmask_readback", 32'h0000_0010);
        address = 3'd3;
        in_port = 8'h50;
        tick(2);
        push("irq_low_at_2_edges", SIG_IRQ, 32'h0);
        push("edgecap_empty_at_2_edges", SIG_RD, 32'h0);
        tick(1);
        push("irq_high_at_3_edges", SIG_IRQ, 32'h1);
        push("edgecap_bit4", SIG_RD, 32'h0000_0010);
        tick(1);
        bus_write(3'd3, 32'h0000_0010, 1'b1);
        push("irq_after_w1c", SIG_IRQ, 32'h0);
        read_exp(3'd3, "edgecap_after_w1c", 32'h0);

        // Edge coinciding with W1C: event wins
        in_port = 8'h52;
        tick(3);
        in_port = 8'h50;
        tick(4);
        in_port = 8'h52;
        tick(2);
        bus_write(3'd3, 32'h0000_0002, 1'b1);
        read_exp(3'd3, "edge_beats_clear", 32'h0000_0002);
        push("irq_unmasked_bit", SIG_IRQ, 32'h0);

        // Dir 0->1 keeps capture; edges on outputs are not captured
        bus_write(3'd1, 32'h0000_0002, 1'b1);
        read_exp(3'd3, "dir_change_keeps_cap", 32'h0000_0002);
        bus_write(3'd3, 32'h0000_0002, 1'b1);
        in_port = 8'h50;
        tick(4);
        in_port = 8'h52;
        tick(4);
        read_exp(3'd3, "no_cap_on_output", 32'h0);
        read_exp(3'd0, "data_read_dir02", 32'h0000_0050);

        // Asynchronous reset mid-traffic
        bus_write(3'd0, 32'h0000_0033, 1'b1);
        bus_write(3'd1, 32'h0000_00FF, 1'b1);
        push("pre_rst_out", SIG_OUT, 32'h0000_0033);
        push("pre_rst_oe", SIG_OE, 32'h0000_00FF);
        tick(1);
        address = 3'd1;
        #2;
        reset_n = 1'b0;
        #1;
        push("async_rst_out", SIG_OUT, 32'h0000_00A5);
        push("async_rst_oe", SIG_OE, 32'h0);
        push("async_rst_irq", SIG_IRQ, 32'h0);
        push("async_rst_dir", SIG_RD, 32'h0);
        tick(2);
        reset_n = 1'b1;
        tick(6);
        read_exp(3'd3, "bit1_high_through_reset", 32'h0);
        read_exp(3'd0, "post_reset_data", 32'h0000_0052);
        read_exp(3'd2, "post_reset_irqmask", 32'h0);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && sb_q.size() != 0; i++) tick(1);
        if (sb_q.size() != 0) begin
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
            n_miss += sb_q.size();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
